fifo_rd_stream_adapter: RTL



---
 rtl/fifo_rd_stream_adapter.sv | 91 +++++++++
 1 files changed

// File: rtl/fifo_rd_stream_adapter.sv
// Read-side adapter: turns the async FIFO's empty/rd_en/registered-data interface into a
// valid/ready stream via a small prefetch ring. Optional FIFO_RD_STATS_EN adds word_count.
module fifo_rd_stream_adapter #(
  parameter int unsigned data_width = 8,
  parameter int unsigned buf_depth  = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [data_width-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [data_width-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [15:0]           word_count
`endif
);

  localparam int unsigned ptr_w = (buf_depth > 1) ? $clog2(buf_depth) : 1;
  localparam int unsigned occ_w = $clog2(buf_depth + 1);
  localparam logic [ptr_w-1:0] last_ptr  = ptr_w'(buf_depth - 1);
  localparam logic [occ_w:0]   depth_ext = (occ_w + 1)'(buf_depth);

  logic [data_width-1:0] mem [buf_depth];
  logic [ptr_w-1:0]      head_q, head_d;
  logic [ptr_w-1:0]      tail_q, tail_d;
  logic [occ_w-1:0]      occ_q, occ_d;
  logic                  inflight_q;
  logic                  capture;
  logic                  pop;
  logic [data_width-1:0] m_data_d;

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == last_ptr) ? '0 : p + 1'b1;
  endfunction

  assign capture = inflight_q;
  assign pop     = m_valid & m_ready;

  always_comb begin
    // Counting the inflight word reserves its slot, so a capture never finds the ring full.
    fifo_rd_en = ~RST & ~fifo_empty &
                 (({1'b0, occ_q} + (occ_w + 1)'(inflight_q)) < depth_ext);
    head_d = pop     ? ptr_inc(head_q) : head_q;
    tail_d = capture ? ptr_inc(tail_q) : tail_q;
    occ_d  = occ_q + occ_w'(capture) - occ_w'(pop);
    // New head is the entry being written this edge only when the ring would otherwise be empty.
    if (capture && (tail_q == head_d)) begin
      m_data_d = fifo_data_out;
    end else begin
      m_data_d = mem[head_d];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= fifo_rd_en;
      m_valid    <= (occ_d != '0);
      m_data     <= m_data_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (capture) begin
      mem[tail_q] <= fifo_data_out;
    end
  end

`ifdef FIFO_RD_STATS_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      word_count <= '0;
    end else if (pop) begin
      word_count <= word_count + 16'd1;
    end
  end
`endif

endmodule
